// File: rtl/sha256_stream_padder.sv
// Byte-stream front-end for sha256_core: accepts message bytes, applies SHA-2
// padding, issues 512-bit blocks over init/next and captures the final digest.
module sha256_stream_padder #(
  parameter bit MODE  = 1'b1,
  parameter int LEN_W = 61
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [7:0]   s_data,
  input  logic         s_last,
  input  logic         s_empty,
  output logic         core_init,
  output logic         core_next,
  output logic         core_mode,
  output logic [511:0] core_block,
  input  logic         core_ready,
  input  logic [255:0] core_digest,
  input  logic         core_digest_valid,
  output logic [255:0] digest,
  output logic         digest_valid,
  output logic         busy
);

  typedef enum logic [2:0] {
    COLLECT, PAD80, PAD_ZERO, PAD_LEN, ISSUE, WAIT_LOW, WAIT_RDY
  } state_t;

  state_t           r_state, w_next;
  logic [6:0]       r_idx;
  logic [LEN_W-1:0] r_count;
  logic             r_first, r_pend, r_padding, r_final;
  logic [511:0]     r_block;
  logic [255:0]     r_digest;
  logic             r_dvalid, r_busy;

  logic [63:0] w_bitlen;
  logic [7:0]  w_lenbyte, w_byte;
  logic [8:0]  w_bitpos;
  logic [6:0]  w_idx_after;
  logic        w_has_data, w_ready, w_accept, w_wr, w_init, w_nxt, w_done;

  assign w_has_data  = !(s_last && s_empty);
  assign w_idx_after = r_idx + {6'd0, w_has_data};
  assign w_accept    = s_valid && w_ready;
  assign w_bitlen    = 64'({r_count, 3'b000});
  // bytes 56..63 carry the bit length MSB first; idx[2:0] selects the byte
  assign w_lenbyte   = 8'(w_bitlen >> {~r_idx[2:0], 3'b000});
  assign w_bitpos    = {~r_idx[5:0], 3'b000};

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= COLLECT;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_wr    = 1'b0;
    w_byte  = s_data;
    w_init  = 1'b0;
    w_nxt   = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      COLLECT: begin
        w_ready = (r_idx < 7'd64);
        if (w_accept) begin
          w_wr = w_has_data;
          if (s_last)                  w_next = (w_idx_after == 7'd64) ? ISSUE : PAD80;
          else if (w_idx_after == 7'd64) w_next = ISSUE;
        end
      end
      PAD80: begin
        w_wr   = 1'b1;
        w_byte = 8'h80;
        w_next = (r_idx == 7'd63) ? ISSUE : PAD_ZERO;
      end
      PAD_ZERO: begin
        if (r_idx == 7'd56)      w_next = PAD_LEN;
        else if (r_idx == 7'd64) w_next = ISSUE;
        else begin
          w_wr   = 1'b1;
          w_byte = 8'h00;
        end
      end
      PAD_LEN: begin
        w_wr   = 1'b1;
        w_byte = w_lenbyte;
        if (r_idx == 7'd63) w_next = ISSUE;
      end
      ISSUE: begin
        if (core_ready) begin
          w_init = r_first;
          w_nxt  = !r_first;
          w_next = WAIT_LOW;
        end
      end
      // core_ready may lag the pulse by a cycle, so it is not trusted here
      WAIT_LOW: w_next = WAIT_RDY;
      WAIT_RDY: begin
        if (core_ready) begin
          w_done = 1'b1;
          if (r_final)        w_next = COLLECT;
          else if (r_pend)    w_next = PAD80;
          else if (r_padding) w_next = PAD_ZERO;
          else                w_next = COLLECT;
        end
      end
      default: w_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_idx     <= '0;
      r_count   <= '0;
      r_first   <= 1'b1;
      r_pend    <= 1'b0;
      r_padding <= 1'b0;
      r_final   <= 1'b0;
      r_block   <= '0;
      r_digest  <= '0;
      r_dvalid  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      if (w_wr) begin
        r_block[w_bitpos +: 8] <= w_byte;
        r_idx                  <= r_idx + 7'd1;
      end
      if (r_state == COLLECT && w_accept) begin
        if (!r_busy) begin
          r_dvalid <= 1'b0;
          r_busy   <= 1'b1;
        end
        if (w_has_data) r_count <= r_count + {{(LEN_W-1){1'b0}}, 1'b1};
        if (s_last)     r_pend  <= 1'b1;
      end
      if (r_state == PAD80) begin
        r_pend    <= 1'b0;
        r_padding <= 1'b1;
      end
      if (r_state == PAD_LEN && r_idx == 7'd63) r_final <= 1'b1;
      if (w_init || w_nxt) r_first <= 1'b0;
      if (w_done) begin
        r_idx   <= '0;
        r_block <= '0;
        if (r_final) begin
          r_final   <= 1'b0;
          r_padding <= 1'b0;
          r_busy    <= 1'b0;
          r_count   <= '0;
          r_first   <= 1'b1;
          r_dvalid  <= core_digest_valid;
          if (core_digest_valid) r_digest <= core_digest;
        end
      end
    end
  end

  assign s_ready      = w_ready;
  assign core_init    = w_init;
  assign core_next    = w_nxt;
  assign core_mode    = MODE;
  assign core_block   = r_block;
  assign digest       = r_digest;
  assign digest_valid = r_dvalid;
  assign busy         = r_busy;

endmodule

// File: doc/sha256_stream_padder.md
Name: sha256_stream_padder

Overview:
- Byte-stream front-end that acts as initiator for sha256_core: accepts a message as bytes over a valid/ready handshake.
- Applies SHA-2 padding (0x80, zero fill, 64-bit big-endian bit length) and assembles 512-bit blocks.
- Drives the core's init/next/block interface and captures the final digest.
- Sits between the host/DMA stream and sha256_core; it replaces bench-driven stimulus with hardware.

Parameters:
- MODE, 1, value driven on core_mode (1 = SHA-256, 0 = SHA-224).
- LEN_W, 61, width of the message byte counter; bit length = {count, 3'b000} zero-extended to 64 bits.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- s_valid  in  1  input beat valid
- s_ready  out  1  block can accept a beat
- s_data  in  8  message byte
- s_last  in  1  beat is final of message
- s_empty  in  1  with s_last: beat carries no data (zero-length message or terminator); ignored when s_last=0
- core_init  out  1  one-cycle pulse, first block of message
- core_next  out  1  one-cycle pulse, subsequent blocks
- core_mode  out  1  tied to MODE
- core_block  out  512  block buffer, byte 0 at bits [511:504]
- core_ready  in  1  core idle
- core_digest  in  256  core digest
- core_digest_valid  in  1  core digest valid
- digest  out  256  captured digest
- digest_valid  out  1  digest holds result of last message
- busy  out  1  message in progress

Behaviour:
- Reset (reset_n=0 at posedge, any state, including mid-block): state=COLLECT, idx=0, count=0, first=1.
  - s_ready=1; core_init=core_next=0; core_block=0; digest=0; digest_valid=0; busy=0.
- Handshake: beat accepted when s_valid && s_ready at posedge. s_ready=1 only in COLLECT with idx<64.
- COLLECT: each accepted non-empty beat writes s_data at byte idx; idx++, count++, busy=1.
  - First accepted beat of a message clears digest_valid.
  - idx reaching 64 without last -> ISSUE, then back to COLLECT.
  - Accepted s_last -> sets pad_pend. If idx (after write) ==64 -> ISSUE first; otherwise -> PAD80.
- PAD80: write 0x80 at idx, idx++, clear pad_pend. If idx becomes 64 -> ISSUE (non-final), then PAD_ZERO at idx 0; else PAD_ZERO.
- PAD_ZERO: one zero byte per cycle.
  - idx==56 -> PAD_LEN.
  - idx==64 -> ISSUE (non-final), then PAD_ZERO at idx 0.
- PAD_LEN: 8 cycles writing bit length MSB first into bytes 56..63, then ISSUE (final).
- ISSUE: wait until core_ready=1.
  - Pulse core_init if first=1, else core_next, for exactly one cycle; clear first.
  - core_block stable from this cycle until core_ready is seen high again.
- WAIT_LOW: one cycle, ignores core_ready.
- WAIT_RDY: wait for core_ready=1.
  - Non-final block: idx=0, clear buffer, return to COLLECT or PAD80/PAD_ZERO per pad state.
  - Final block: digest<=core_digest (core_digest_valid must be 1, else digest_valid stays 0); digest_valid=1; busy=0; count=0; first=1 -> COLLECT.
- Block count: 1 block if message length mod 64 <=55, else 2 blocks for the tail.
- At most one of core_init/core_next high in any cycle.
- s_valid while s_ready=0 is ignored; no beat is lost or duplicated.
- digest and digest_valid stay stable until the next message's first accepted beat.

Test Plan:
- "abc" (0x61,0x62,0x63, last on 0x63) -> one core_init, no core_next.
  - core_block = 512'h616263800...0018.
  - digest = BA7816BF8F01CFEA414140DE5DAE2223B00361A396177A9CB410FF61F20015AD, digest_valid=1.
- Empty (single beat s_last=1, s_empty=1) -> core_block = 512'h80 followed by zeros.
  - digest = E3B0C44298FC1C149AFBF4C8996FB92427AE41E4649B934CA495991B7852B855.
- 56-byte "abcdbcdecdef...nopq" -> core_init then core_next.
  - Second block = zeros with length 0x1C0.
  - digest = 248D6A61D20638B8E5C026930C3E6039A33CE45964FF2167F6ECEDD419DB06C1.
- 64 bytes of 0x00 -> block 1 all data; block 2 = 0x80, zeros, length 0x200.
  - Exactly one init and one next pulse.
- Backpressure: toggle s_valid randomly and check s_ready=0 during ISSUE/WAIT/PAD.
  - Same "abc" digest; init pulse width exactly 1 cycle.
- Reset asserted during WAIT_RDY of a 2-block message -> next cycle all outputs at reset values.
  - A subsequent "abc" hashes correctly.
